// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with alignment check, lane steering and bus timeout
module load_store_unit #(
    parameter int Width         = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LS_Start,
    input  logic             LS_Write,
    input  logic [2:0]       LS_Funct3,
    input  logic [Width-1:0] Address,
    input  logic [Width-1:0] Store_Data,
    output logic             LS_Busy,
    output logic             LS_Done,
    output logic [Width-1:0] Load_Data,
    output logic             Misaligned,
    output logic             Bus_Error,
    output logic             Mem_Req,
    output logic             Mem_We,
    output logic [Width-1:0] Mem_Addr,
    output logic [Width-1:0] Mem_WData,
    output logic [3:0]       Mem_BE,
    input  logic [Width-1:0] Mem_RData,
    input  logic             Mem_Ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TimeoutCycles - 1);

    state_t           state_q, state_d;
    logic [Width-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [3:0]       be_q, be_d;
    logic [Width-1:0] wdata_q, wdata_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;
    logic [Width-1:0] load_q, load_d;

    logic             legal;
    logic             aligned;
    logic [3:0]       be_new;
    logic [Width-1:0] wdata_new;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [Width-1:0] rext;

    // Decode the incoming instruction: legality, alignment, byte enables and steered store data
    always_comb begin
        legal     = 1'b0;
        aligned   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = Store_Data;
        case (LS_Funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !LS_Write;
            default:                legal = 1'b0;
        endcase
        case (LS_Funct3[1:0])
            2'b01:   aligned = !Address[0];
            2'b10:   aligned = (Address[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (LS_Funct3[1:0])
            2'b00: begin
                wdata_new = {4{Store_Data[7:0]}};
                if (LS_Write) be_new = 4'b0001 << Address[1:0];
            end
            2'b01: begin
                wdata_new = {2{Store_Data[15:0]}};
                if (LS_Write) be_new = 4'b0011 << {Address[1], 1'b0};
            end
            default: begin
                wdata_new = Store_Data;
                be_new    = 4'b1111;
            end
        endcase
    end

    // Select the addressed lane of the returned word and extend it
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rbyte = Mem_RData[7:0];
            2'b01:   rbyte = Mem_RData[15:8];
            2'b10:   rbyte = Mem_RData[23:16];
            default: rbyte = Mem_RData[31:24];
        endcase
        rhalf = addr_q[1] ? Mem_RData[31:16] : Mem_RData[15:0];
        case (f3_q)
            3'b000:  rext = {{24{rbyte[7]}}, rbyte};
            3'b100:  rext = {24'b0, rbyte};
            3'b001:  rext = {{16{rhalf[15]}}, rhalf};
            3'b101:  rext = {16'b0, rhalf};
            default: rext = Mem_RData;
        endcase
    end

    // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, pulse completion in DONE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        load_d  = load_q;
        case (state_q)
            IDLE: begin
                if (LS_Start) begin
                    addr_d  = Address;
                    we_d    = LS_Write;
                    f3_d    = LS_Funct3;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    cnt_d   = 8'd0;
                    if (legal && aligned) begin
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (Mem_Ack) begin
                    state_d = DONE;
                    if (!we_q) load_d = rext;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            be_q    <= 4'b0;
            wdata_q <= '0;
            cnt_q   <= 8'd0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            load_q  <= load_d;
        end
    end

    assign Mem_Req    = (state_q == REQ);
    assign Mem_We     = Mem_Req & we_q;
    assign Mem_BE     = Mem_Req ? be_q : 4'b0;
    assign Mem_Addr   = {addr_q[Width-1:2], 2'b00};
    assign Mem_WData  = wdata_q;
    assign LS_Done    = (state_q == DONE);
    assign LS_Busy    = (state_q == REQ) | ((state_q == IDLE) & LS_Start);
    assign Misaligned = mis_q;
    assign Bus_Error  = berr_q;
    assign Load_Data  = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LS_Start, LS_Write;
    logic [2:0]  LS_Funct3;
    logic [31:0] Address, Store_Data;
    logic        LS_Busy, LS_Done, Misaligned, Bus_Error;
    logic [31:0] Load_Data;
    logic        Mem_Req, Mem_We, Mem_Ack;
    logic [31:0] Mem_Addr, Mem_WData, Mem_RData;
    logic [3:0]  Mem_BE;

    load_store_unit #(.Width(32), .TimeoutCycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .LS_Start(LS_Start), .LS_Write(LS_Write), .LS_Funct3(LS_Funct3),
        .Address(Address), .Store_Data(Store_Data),
        .LS_Busy(LS_Busy), .LS_Done(LS_Done), .Load_Data(Load_Data),
        .Misaligned(Misaligned), .Bus_Error(Bus_Error),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_BE(Mem_BE),
        .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic        e_chk = 1'b0;
    logic        e_busy, e_req, e_done, e_mis, e_berr, e_we;
    logic [31:0] e_ld, e_addr, e_wd;
    logic [3:0]  e_be;

    int          req_cnt;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd, cap_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Spec-level model of one access: legality, byte enables, steered data, extended load
    function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rd,
                                  output logic ok, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int nb, off;
        logic [31:0] v, b, h;
        logic [1:0] sz;
        ok  = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz  = f3[1:0];
        nb  = 1 << sz;
        off = int'(a % 32'd4);
        if ((off % nb) != 0) ok = 1'b0;
        be  = w ? 4'(((1 << nb) - 1) << off) : 4'hF;
        if (nb == 1)      wd = (sd & 32'hFF) * 32'h01010101;
        else if (nb == 2) wd = (sd & 32'hFFFF) * 32'h00010001;
        else              wd = sd;
        v = rd >> (8 * off);
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (f3)
            3'd0:    ld = (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    ld = b;
            3'd1:    ld = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    ld = h;
            default: ld = rd;
        endcase
    endfunction

    // Single compare process: DUT outputs against the bench expectations every cycle
    always @(negedge clk) begin
        if (e_chk) begin
            check("LS_Busy",    32'(LS_Busy),    32'(e_busy));
            check("Mem_Req",    32'(Mem_Req),    32'(e_req));
            check("LS_Done",    32'(LS_Done),    32'(e_done));
            check("Misaligned", 32'(Misaligned), 32'(e_mis));
            check("Bus_Error",  32'(Bus_Error),  32'(e_berr));
            check("Load_Data",  Load_Data,       e_ld);
            if (e_req) begin
                check("Mem_Addr", Mem_Addr,       e_addr);
                check("Mem_We",   32'(Mem_We),    32'(e_we));
                check("Mem_BE",   32'(Mem_BE),    32'(e_be));
                if (e_we) check("Mem_WData", Mem_WData, e_wd);
                cap_we   = Mem_We;
                cap_be   = Mem_BE;
                cap_wd   = Mem_WData;
                cap_addr = Mem_Addr;
            end
            if (Mem_Req) req_cnt++;
        end
    end

    task automatic set_idle();
        e_busy = 1'b0; e_req = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
    endtask

    // ack_at: REQ cycle index (0-based) carrying Mem_Ack; >= TO means never
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd, input int ack_at);
        logic ok;
        logic [3:0] be;
        logic [31:0] wd, ld;
        model(w, f3, a, sd, rd, ok, be, wd, ld);
        req_cnt = 0;
        @(posedge clk); #1;
        LS_Start = 1'b1; LS_Write = w; LS_Funct3 = f3; Address = a; Store_Data = sd;
        Mem_Ack = 1'b0;
        set_idle();
        e_busy = 1'b1;
        @(posedge clk); #1;
        LS_Start = 1'b0;
        if (!ok) begin
            e_busy = 1'b0; e_done = 1'b1; e_mis = 1'b1;
        end else begin
            e_addr = a & ~32'd3; e_we = w; e_be = be; e_wd = wd;
            for (int k = 0; k < TO; k++) begin
                e_req = 1'b1; e_busy = 1'b1;
                Mem_Ack   = (k == ack_at);
                Mem_RData = (k == ack_at) ? rd : 32'h5A5A5A5A;
                @(posedge clk); #1;
                Mem_Ack = 1'b0;
                if (k == ack_at) break;
            end
            e_req = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            e_berr = (ack_at >= TO);
            if (ack_at < TO && !w) e_ld = ld;
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0; LS_Start = 1'b0; LS_Write = 1'b0; LS_Funct3 = 3'b0;
        Address = '0; Store_Data = '0; Mem_RData = '0; Mem_Ack = 1'b0;
        e_ld = '0; e_addr = '0; e_wd = '0; e_be = '0; e_we = 1'b0;
        set_idle();
        req_cnt = 0;
        @(posedge clk); #1;
        check("rst Mem_Req",   32'(Mem_Req),   0);
        check("rst LS_Busy",   32'(LS_Busy),   0);
        check("rst LS_Done",   32'(LS_Done),   0);
        check("rst Load_Data", Load_Data,      0);
        check("rst Flags",     32'({Misaligned, Bus_Error}), 0);
        rst_n = 1'b1;
        e_chk = 1'b1;

        run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        check("LW data",  Load_Data, 32'hDEADBEEF);
        check("LW addr",  cap_addr,  32'h100);
        check("LW be",    32'(cap_be), 32'hF);
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 0);
        check("LB data",  Load_Data, 32'hFFFFFF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 1);
        check("LBU data", Load_Data, 32'h00000080);
        run_txn(1'b0, 3'd1, 32'h102, 32'h0, 32'h80123456, 0);
        check("LH data",  Load_Data, 32'hFFFF8012);

        run_txn(1'b1, 3'd0, 32'h201, 32'h000000AB, 32'h0, 1);
        check("SB we",    32'(cap_we), 1);
        check("SB be",    32'(cap_be), 32'h2);
        check("SB wdata", cap_wd,    32'hABABABAB);
        check("SB addr",  cap_addr,  32'h200);
        check("SB hold",  Load_Data, 32'hFFFF8012);
        run_txn(1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0, 0);
        check("SH be",    32'(cap_be), 32'hC);
        check("SH wdata", cap_wd,    32'h12341234);
        run_txn(1'b1, 3'd2, 32'h300, 32'h11223344, 32'h0, 2);
        check("SW wdata", cap_wd,    32'h11223344);

        run_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        check("LW mis req",  32'(req_cnt), 0);
        check("LW mis hold", Load_Data, 32'hFFFF8012);
        run_txn(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
        check("f3=011 req",  32'(req_cnt), 0);
        run_txn(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
        check("S f3=100 req", 32'(req_cnt), 0);

        run_txn(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 99);
        check("timeout req cycles", 32'(req_cnt), TO);
        check("timeout hold", Load_Data, 32'hFFFF8012);
        run_txn(1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, TO - 1);
        check("late ack req cycles", 32'(req_cnt), TO);
        check("late ack data", Load_Data, 32'hCAFEF00D);
        run_txn(1'b0, 3'd5, 32'h106, 32'h0, 32'h9ABC1234, 0);
        check("LHU data", Load_Data, 32'h00009ABC);

        // Reset while waiting for an ack
        @(posedge clk); #1;
        LS_Start = 1'b1; LS_Write = 1'b0; LS_Funct3 = 3'd2; Address = 32'h500; Store_Data = '0;
        e_busy = 1'b1;
        @(posedge clk); #1;
        LS_Start = 1'b0;
        e_req = 1'b1; e_addr = 32'h500; e_we = 1'b0; e_be = 4'hF;
        @(posedge clk); #1;
        e_chk = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst mid Mem_Req",   32'(Mem_Req),   0);
        check("rst mid LS_Busy",   32'(LS_Busy),   0);
        check("rst mid Load_Data", Load_Data,      0);
        check("rst mid LS_Done",   32'(LS_Done),   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        e_ld = '0;
        set_idle();
        req_cnt = 0;
        e_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post rst no req", 32'(req_cnt), 0);
        run_txn(1'b0, 3'd2, 32'h600, 32'h0, 32'h13579BDF, 1);
        check("post rst LW", Load_Data, 32'h13579BDF);

        @(posedge clk); #1;
        e_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
